// File: rtl/mb_rtu_frame_parser_if.sv
// Byte-stream input and decoded request/error outputs of the Modbus RTU frame parser.
// The receiver front-end drives the master side; the parser sits on the slave side.
interface mb_rtu_frame_parser_if;
  logic [7:0]  rx_byte;
  logic        rx_done;
  logic        frame_end;
  logic        req_valid;
  logic [7:0]  req_func;
  logic [15:0] req_reg_addr;
  logic [15:0] req_reg_val;
  logic        req_bcast;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output rx_byte, rx_done, frame_end,
    input  req_valid, req_func, req_reg_addr, req_reg_val, req_bcast,
           err_valid, err_code, busy
  );

  modport slave (
    input  rx_byte, rx_done, frame_end,
    output req_valid, req_func, req_reg_addr, req_reg_val, req_bcast,
           err_valid, err_code, busy
  );
endinterface

// File: rtl/mb_rtu_frame_parser.sv
// Modbus RTU frame parser: buffers one frame, runs a bit-serial CRC-16 over every byte,
// then validates address/function/length and emits a one-cycle request or error strobe.
module mb_rtu_frame_parser #(
  parameter logic [7:0]  SLAVE_ADDR = 8'h01,
  parameter int unsigned MAX_LEN    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mb_rtu_frame_parser_if.slave rx_bus
);

  localparam int CW = $clog2(MAX_LEN + 2);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] LEN_MIN = CW'(4);
  localparam logic [CW-1:0] LEN_RTU = CW'(8);
  localparam logic [CW-1:0] LEN_MAX = CW'(MAX_LEN);
  localparam logic [CW-1:0] LEN_SAT = CW'(MAX_LEN + 1);

  localparam logic [1:0] ERR_CRC  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_FUNC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    crc_q, crc_d;
  logic [3:0]     shift_q, shift_d;
  logic           ovr_q, ovr_d;
  logic           pend_q, pend_d;
  logic           req_valid_q, req_valid_d;
  logic [7:0]     req_func_q, req_func_d;
  logic [15:0]    req_addr_q, req_addr_d;
  logic [15:0]    req_val_q, req_val_d;
  logic           req_bcast_q, req_bcast_d;
  logic           err_valid_q, err_valid_d;
  logic [1:0]     err_code_q, err_code_d;

  logic [7:0]     buf_q [MAX_LEN];
  logic           wr_en;
  logic [AW-1:0]  wr_idx;
  logic           crc_busy;
  logic [7:0]     f_addr, f_func;

  function automatic logic [15:0] crc_step(input logic [15:0] c);
    return c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  assign crc_busy = (shift_q != 4'd0);
  assign wr_idx   = cnt_q[AW-1:0];
  assign f_addr   = buf_q[0];
  assign f_func   = buf_q[1];

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    shift_d     = shift_q;
    ovr_d       = ovr_q;
    pend_d      = pend_q;
    req_valid_d = 1'b0;
    req_func_d  = req_func_q;
    req_addr_d  = req_addr_q;
    req_val_d   = req_val_q;
    req_bcast_d = req_bcast_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    wr_en       = 1'b0;

    if (crc_busy) begin
      crc_d   = crc_step(crc_q);
      shift_d = shift_q - 4'd1;
    end

    // A byte is taken only with the shifter idle; it is XORed in now and shifted over 8 clocks.
    if (state_q != ST_CHECK && rx_bus.rx_done) begin
      if (crc_busy) begin
        ovr_d = 1'b1;
      end else begin
        wr_en   = (cnt_q < LEN_MAX);
        crc_d   = crc_q ^ {8'h00, rx_bus.rx_byte};
        shift_d = 4'd8;
        if (cnt_q != LEN_SAT) cnt_d = cnt_q + CW'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_bus.rx_done) begin
          state_d = ST_RECV;
          pend_d  = rx_bus.frame_end;
        end
      end
      ST_RECV: begin
        if (rx_bus.frame_end) pend_d = 1'b1;
        if ((rx_bus.frame_end || pend_q) && shift_d == 4'd0) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        crc_d   = 16'hFFFF;
        shift_d = 4'd0;
        ovr_d   = 1'b0;
        pend_d  = 1'b0;
        if (cnt_q < LEN_MIN || cnt_q > LEN_MAX || ovr_q) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_LEN;
        end else if (crc_q != 16'h0000) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_CRC;
        end else if (f_addr != SLAVE_ADDR && f_addr != 8'h00) begin
          // Frame for another node: dropped without any strobe.
        end else if (f_func != 8'h03 && f_func != 8'h06) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_FUNC;
        end else if (cnt_q != LEN_RTU) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_LEN;
        end else if (f_func == 8'h03 && f_addr == 8'h00) begin
          // Broadcast reads cannot be answered, so they are dropped silently.
        end else begin
          req_valid_d = 1'b1;
          req_func_d  = f_func;
          req_addr_d  = {buf_q[2], buf_q[3]};
          req_val_d   = {buf_q[4], buf_q[5]};
          req_bcast_d = (f_addr == 8'h00);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      crc_q       <= 16'hFFFF;
      shift_q     <= 4'd0;
      ovr_q       <= 1'b0;
      pend_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_func_q  <= 8'h00;
      req_addr_q  <= 16'h0000;
      req_val_q   <= 16'h0000;
      req_bcast_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      shift_q     <= shift_d;
      ovr_q       <= ovr_d;
      pend_q      <= pend_d;
      req_valid_q <= req_valid_d;
      req_func_q  <= req_func_d;
      req_addr_q  <= req_addr_d;
      req_val_q   <= req_val_d;
      req_bcast_q <= req_bcast_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  // NOTE: the frame buffer has no reset; entries are only read after the length check proves them written.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= rx_bus.rx_byte;
  end

  assign rx_bus.req_valid    = req_valid_q;
  assign rx_bus.req_func     = req_func_q;
  assign rx_bus.req_reg_addr = req_addr_q;
  assign rx_bus.req_reg_val  = req_val_q;
  assign rx_bus.req_bcast    = req_bcast_q;
  assign rx_bus.err_valid    = err_valid_q;
  assign rx_bus.err_code     = err_code_q;
  assign rx_bus.busy         = (state_q != ST_IDLE);

endmodule
